hs_byte_packer: RTL and testbench
=================================

// Module: hs_byte_packer
// PURPOSE
//  Downstream consumer of the valid/ready slave stage: accepts IN_W-bit beats and packs
//  RATIO consecutive beats into one OUT_W-bit word on a valid/ready output.
//  First beat accepted lands in the least-significant lane (little-endian).
//  Sustains one input beat per cycle under continuous out_ready.
//  Feeds wide-word consumers (memory writers, checkers) downstream.
// PARAMETERS
//  IN_W   8  input beat width in bits
//  RATIO  4  beats per output word; legal range 2..16
//  OUT_W  (localparam) IN_W*RATIO, output word width
// PORTS
//  clk        in   1       single clock; all state changes on its rising edge
//  rst        in   1       asynchronous, active-low reset (0 = reset)
//  in_valid   in   1       upstream beat valid
//  in_ready   out  1       packer can accept a beat this cycle
//  in_data    in   IN_W    beat payload
//  out_valid  out  1       packed word valid
//  out_ready  in   1       downstream accepts word
//  out_data   out  OUT_W   packed word; lane k = k-th beat accepted
//  flush      in   1       [PACKER_FLUSH_EN only] one-cycle pulse: emit partial word
//  out_keep   out  RATIO   [PACKER_FLUSH_EN only] per-lane valid mask
// BEHAVIOUR
//  - Reset (rst=0, async): cnt=0, acc=0, out_valid=0, out_data=0, out_keep=0, flush_pend=0.
//    in_ready=0 while rst=0. Reset mid-word discards the partial word and any held output word.
//  - Beat handshake on in_valid&in_ready; word handshake on out_valid&out_ready.
//  - Fill counter cnt 0..RATIO-1 acts as FSM: FILL_k (k beats held). Beat at cnt<RATIO-1:
//    acc lane cnt <= in_data, cnt++.
//  - Beat at cnt==RATIO-1 (completing beat): {in_data, acc lanes} loads out_data in the same
//    edge, out_valid<=1, cnt wraps to 0. Latency: out_valid rises one cycle after the completing beat.
//  - Output slot free = !out_valid | out_ready.
//  - in_ready = rst & (cnt!=RATIO-1 | slot free) & !flush_pend.
//    Only the completing beat stalls on backpressure.
//  - Simultaneous word drain and completing beat: new word replaces old in one edge,
//    out_valid stays 1, no bubble.
//  - out_valid&!out_ready: out_data, out_keep held stable until accepted.
//  - in_data ignored when in_valid=0; lanes not yet written hold stale data (not zeroed).
// CONFIGURATION
//  PACKER_FLUSH_EN defined:
//  - flush and out_keep exist.
//  - flush pulse sets flush_pend (with a beat on the same edge, that beat is included first).
//  - Pending flush with cnt>0: on the first edge with slot free, emit acc with unused lanes zeroed;
//    out_keep=(1<<cnt)-1; cnt<=0; flush_pend<=0.
//  - in_ready=0 while flush_pend.
//  - Flush with cnt==0 (after any same-edge beat): cleared without output.
//  - Full words carry out_keep=all ones.
//  PACKER_FLUSH_EN undefined:
//  - No flush/out_keep ports; flush_pend constant 0.
//  - Partial words only leave via reset.
// STRUCTURE
//  - Package hs_pkg: IN_W/RATIO defaults, typedef cnt_t (clog2 RATIO), lane-index helper,
//    OUT_W derivation function.
//  - Sub-module hs_out_slot: one-entry output register (load/hold/drain, out_valid,
//    slot-free term), reused by later stream stages.
//  - Packer holds only cnt, acc, flush_pend.
// TESTING
//  1. Reset: rst=0 mid-operation -> out_valid=0, in_ready=0, cnt=0 asynchronously; after release
//     in_ready=1 next cycle.
//  2. Stream bytes 01,02,03,04,05..08 with out_ready=1 -> out_data 32'h04030201 then 32'h08070605;
//     in_ready never drops; out_valid one cycle after beats 4 and 8.
//  3. Backpressure: out_ready=0, send 01..08 -> first word held; in_ready=0 only at completing beat 08;
//     raise out_ready -> 04030201, then 08070605 next cycle.
//  4. Gaps: in_valid pattern 1,0,0,1,0,1,1 with bytes 11,22,33,44 -> single word 32'h44332211;
//     no extra out_valid.
//  5. [PACKER_FLUSH_EN] send AA,BB then flush pulse -> out_data 32'h0000BBAA, out_keep 4'b0011;
//     flush with cnt==0 -> no output.
//  6. [PACKER_FLUSH_EN] flush during held full word (out_ready=0) -> in_ready=0 until drain;
//     partial emitted cycle after drain.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared definitions for the valid/ready stream stages.
// Holds default beat geometry, the fill-counter type and small width/lane helpers.
package hs_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int RATIO_DEF = 4;
    localparam int RATIO_MAX = 16;

    // Sized for the largest legal ratio so a single type serves every packer instance.
    typedef logic [$clog2(RATIO_MAX)-1:0] cnt_t;

    // Bit offset of lane 'lane' in a word built from w-bit lanes.
    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

    // Width of a packed word holding 'ratio' beats of 'in_w' bits.
    function automatic int out_w(input int in_w, input int ratio);
        return in_w * ratio;
    endfunction

endpackage

// File: rtl/hs_out_slot.sv
// One-entry valid/ready output register: load, hold under backpressure, drain.
// slot_free tells the producer a new entry may be loaded on this edge, including
// the edge on which the current entry drains.
module hs_out_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         slot_free
);

    assign slot_free = !out_valid || out_ready;

    // Load replaces the entry (even while draining); otherwise drain on accept, else hold.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hs_byte_packer.sv
// Packs RATIO consecutive IN_W-bit beats into one OUT_W-bit word, first beat in lane 0.
// Only the completing beat waits for the output slot, so a drained slot and a new
// word can swap on the same edge and the input sustains one beat per cycle.
// Optional feature macro PACKER_FLUSH_EN: adds a flush pulse that emits a partial
// word (unused lanes zeroed) and an out_keep lane mask.
module hs_byte_packer
    import hs_pkg::*;
#(
    parameter  int IN_W  = IN_W_DEF,
    parameter  int RATIO = RATIO_DEF,
    localparam int OUT_W = out_w(IN_W, RATIO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef PACKER_FLUSH_EN
   ,input  logic             flush,
    output logic [RATIO-1:0] out_keep
`endif
);

    localparam int   ACC_W = IN_W * (RATIO - 1);
    localparam cnt_t LAST  = cnt_t'(RATIO - 1);
`ifdef PACKER_FLUSH_EN
    localparam int   SLOT_W = OUT_W + RATIO;
`else
    localparam int   SLOT_W = OUT_W;
`endif

    cnt_t              cnt;
    logic [ACC_W-1:0]  acc;
    logic              flush_pend;
    logic              slot_free;
    logic              beat;
    logic              complete;
    logic              load;
    logic [SLOT_W-1:0] load_data;
    logic [SLOT_W-1:0] slot_data;

    assign in_ready = rst && (cnt != LAST || slot_free) && !flush_pend;
    assign beat     = in_valid && in_ready;
    assign complete = beat && (cnt == LAST);

`ifdef PACKER_FLUSH_EN
    logic              flush_done;
    logic              flush_emit;
    logic [ACC_W-1:0]  acc_part;
    logic [RATIO-1:0]  part_keep;

    // A pending flush retires at once on an empty packer, else when the slot can take the partial.
    assign flush_done = flush_pend && (cnt == '0 || slot_free);
    assign flush_emit = flush_done && (cnt != '0);

    // Partial word: keep lanes already written, zero the rest, and mark the kept lanes.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        acc_part  = '0;
        part_keep = '0;
        for (int k = 0; k < RATIO - 1; k++) begin
            if (cnt_t'(k) < cnt) begin
                acc_part[lane_lsb(k, IN_W) +: IN_W] = acc[lane_lsb(k, IN_W) +: IN_W];
            end
        end
        for (int k = 0; k < RATIO; k++) begin
            part_keep[k] = cnt_t'(k) < cnt;
        end
    end

    assign load      = complete || flush_emit;
    assign load_data = complete ? {{RATIO{1'b1}}, in_data, acc}
                                : {part_keep, {IN_W{1'b0}}, acc_part};
    assign out_data  = slot_data[OUT_W-1:0];
    assign out_keep  = slot_data[OUT_W +: RATIO];

    // A flush pulse arms the request; it clears once the partial word has been handed off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_pend <= 1'b0;
        end else if (flush) begin
            flush_pend <= 1'b1;
        end else if (flush_done) begin
            flush_pend <= 1'b0;
        end
    end
`else
    assign flush_pend = 1'b0;
    assign load       = complete;
    assign load_data  = {in_data, acc};
    assign out_data   = slot_data;
`endif

    // Fill counter and lane accumulator: store each non-final beat in its lane, wrap on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (beat) begin
            if (complete) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (cnt == cnt_t'(k)) begin
                        acc[lane_lsb(k, IN_W) +: IN_W] <= in_data;
                    end
                end
            end
        end
`ifdef PACKER_FLUSH_EN
        else if (flush_done) begin
            cnt <= '0;
        end
`endif
    end

    hs_out_slot #(
        .W (SLOT_W)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (slot_data),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_hs_byte_packer.sv
// Directed bench for hs_byte_packer (IN_W=8, RATIO=4).
// Expected words come from a small lane model pushed into a scoreboard at stimulus
// time; a negedge monitor pops and compares on every output handshake.
// Flush scenarios run only when PACKER_FLUSH_EN is defined.
module tb_hs_byte_packer;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PACKER_FLUSH_EN
    logic        flush;
    logic [3:0]  out_keep;
`endif

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t e;
    logic [7:0] m_lane [4];
    int   m_cnt = 0;

    always #5 clk = ~clk;

    hs_byte_packer #(
        .IN_W  (8),
        .RATIO (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PACKER_FLUSH_EN
       ,.flush     (flush),
        .out_keep  (out_keep)
`endif
    );

    task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_beat(input logic [7:0] d);
        m_lane[m_cnt] = d;
        if (m_cnt == 3) begin
            sb.push_back('{data: {d, m_lane[2], m_lane[1], m_lane[0]}, keep: 4'hF});
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic model_flush();
        logic [31:0] dd;
        logic [3:0]  kk;
        dd = '0;
        kk = '0;
        for (int i = 0; i < m_cnt; i++) begin
            dd[i*8 +: 8] = m_lane[i];
            kk[i]        = 1'b1;
        end
        if (m_cnt > 0) sb.push_back('{data: dd, keep: kk});
        m_cnt = 0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            sync();
            in_data = 8'($urandom);
        end
    endtask

    // Offer one beat; optionally require in_ready at once and check out_valid in that cycle.
    task automatic send(input logic [7:0] d, input bit chk_rdy, input int exp_ov);
        int budget;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        if (chk_rdy) check(64'(in_ready), 64'd1, "in_ready_stream");
        if (exp_ov >= 0) check(64'(out_valid), 64'(exp_ov), "out_valid_timing");
        budget = 0;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check(64'(in_ready), 64'd1, "in_ready_timeout");
        if (in_ready) begin
            sync();
            model_beat(d);
        end else begin
            sync();
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Scoreboard side: a handshake seen at negedge completes on the following rising edge.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            check(64'(sb.size() != 0), 64'd1, "unexpected_word");
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check(64'(out_data), 64'(e.data), "word_data");
`ifdef PACKER_FLUSH_EN
                check(64'(out_keep), 64'(e.keep), "word_keep");
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
        flush     = 1'b0;
`endif

        // Reset state and release
        @(negedge clk);
        check(64'(out_valid), 64'd0, "reset_out_valid");
        check(64'(in_ready), 64'd0, "reset_in_ready");
        check(64'(out_data), 64'd0, "reset_out_data");
        sync();
        rst = 1'b1;
        @(negedge clk);
        check(64'(in_ready), 64'd1, "release_in_ready");

        // Asynchronous reset with a held word and a partial word in flight
        sync();
        send(8'h01, 1'b1, -1);
        send(8'h02, 1'b1, -1);
        send(8'h03, 1'b1, -1);
        send(8'h04, 1'b1, -1);
        send(8'h05, 1'b1, -1);
        @(negedge clk);
        check(64'(out_valid), 64'd1, "held_before_reset");
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check(64'(out_valid), 64'd0, "async_rst_out_valid");
        check(64'(in_ready), 64'd0, "async_rst_in_ready");
        check(64'(out_data), 64'd0, "async_rst_out_data");
        sb.delete();
        m_cnt = 0;
        sync();
        rst = 1'b1;
        @(negedge clk);
        check(64'(in_ready), 64'd1, "rerelease_in_ready");
        check(64'(out_valid), 64'd0, "rerelease_out_valid");

        // Continuous stream, out_ready high
        sync();
        out_ready = 1'b1;
        send(8'h01, 1'b1, 0);
        send(8'h02, 1'b1, 0);
        send(8'h03, 1'b1, 0);
        send(8'h04, 1'b1, 0);
        send(8'h05, 1'b1, 1);
        send(8'h06, 1'b1, 0);
        send(8'h07, 1'b1, 0);
        send(8'h08, 1'b1, 0);
        @(negedge clk);
        check(64'(out_valid), 64'd1, "stream_word2_latency");
        sync();
        @(negedge clk);
        check(64'(out_valid), 64'd0, "stream_idle");
        check(64'(sb.size()), 64'd0, "stream_drained");

        // Backpressure: only the completing beat stalls
        sync();
        out_ready = 1'b0;
        send(8'h01, 1'b1, -1);
        send(8'h02, 1'b1, -1);
        send(8'h03, 1'b1, -1);
        send(8'h04, 1'b1, -1);
        send(8'h05, 1'b1, 1);
        send(8'h06, 1'b1, 1);
        send(8'h07, 1'b1, 1);
        in_valid = 1'b1;
        in_data  = 8'h08;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check(64'(in_ready), 64'd0, "bp_stall_in_ready");
            check(64'(out_valid), 64'd1, "bp_hold_valid");
            check(64'(out_data), 64'h04030201, "bp_hold_data");
            sync();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check(64'(in_ready), 64'd1, "bp_release_in_ready");
        sync();
        model_beat(8'h08);
        in_valid = 1'b0;
        @(negedge clk);
        check(64'(out_valid), 64'd1, "bp_no_bubble");
        sync();
        @(negedge clk);
        check(64'(out_valid), 64'd0, "bp_idle");
        check(64'(sb.size()), 64'd0, "bp_drained");

        // Gapped input: valid pattern 1,0,0,1,0,1,1
        sync();
        send(8'h11, 1'b1, -1);
        idle(2);
        send(8'h22, 1'b1, -1);
        idle(1);
        send(8'h33, 1'b1, -1);
        send(8'h44, 1'b1, -1);
        @(negedge clk);
        check(64'(out_valid), 64'd1, "gap_word_valid");
        idle(4);
        @(negedge clk);
        check(64'(out_valid), 64'd0, "gap_no_extra");
        check(64'(sb.size()), 64'd0, "gap_drained");

`ifdef PACKER_FLUSH_EN
        // Flush of a two-beat partial word, then a flush on an empty packer
        sync();
        send(8'hAA, 1'b1, -1);
        send(8'hBB, 1'b1, -1);
        flush = 1'b1;
        model_flush();
        sync();
        flush = 1'b0;
        @(negedge clk);
        check(64'(in_ready), 64'd0, "flush_pend_in_ready");
        @(negedge clk);
        check(64'(out_valid), 64'd1, "flush_partial_valid");
        check(64'(out_data), 64'h0000BBAA, "flush_partial_data");
        check(64'(out_keep), 64'h3, "flush_partial_keep");
        check(64'(in_ready), 64'd1, "flush_done_in_ready");
        sync();
        flush = 1'b1;
        sync();
        flush = 1'b0;
        idle(3);
        @(negedge clk);
        check(64'(out_valid), 64'd0, "flush_empty_no_word");
        check(64'(in_ready), 64'd1, "flush_empty_in_ready");

        // Flush while a full word is held under backpressure
        sync();
        out_ready = 1'b0;
        send(8'h01, 1'b1, -1);
        send(8'h02, 1'b1, -1);
        send(8'h03, 1'b1, -1);
        send(8'h04, 1'b1, -1);
        send(8'h05, 1'b1, 1);
        send(8'h06, 1'b1, 1);
        flush = 1'b1;
        model_flush();
        sync();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check(64'(in_ready), 64'd0, "flush_bp_in_ready");
            check(64'(out_data), 64'h04030201, "flush_bp_hold_data");
            sync();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check(64'(in_ready), 64'd0, "flush_drain_in_ready");
        sync();
        @(negedge clk);
        check(64'(out_valid), 64'd1, "flush_after_drain_valid");
        check(64'(out_keep), 64'h3, "flush_after_drain_keep");
        check(64'(in_ready), 64'd1, "flush_after_drain_in_ready");
        sync();
        @(negedge clk);
        check(64'(out_valid), 64'd0, "flush_bp_idle");
`endif

        sync();
        check(64'(sb.size()), 64'd0, "scoreboard_empty");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
